// File: rtl/rom_ctrl_pkg.sv
// Shared constants, FSM state type and opcode helper for the ROM fetch controller.
package rom_ctrl_pkg;

  localparam int              DATA_WIDTH        = 16;
  localparam int              ROM_DEPTH_DEFAULT = 16;
  localparam logic [3:0]      ROM_OP            = 4'h3;
  localparam logic [3:0]      ROM_DATA_READ     = 4'h1;
  localparam logic [15:0]     HALT_OPCODE       = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // A constant word is only legal for execute if its opcode high byte is the data-read class.
  function automatic logic isDataReadOpcode(input logic [DATA_WIDTH-1:0] opcode);
    return opcode[15:8] == {ROM_OP, ROM_DATA_READ};
  endfunction

endpackage

// File: rtl/rom_fetch_ctrl_if.sv
// Bundles the control, decode slot, execute data-read and ROM port signals of the fetch controller.
interface rom_fetch_ctrl_if;

  logic                                  start;
  logic [rom_ctrl_pkg::DATA_WIDTH-1:0]   start_addr;
  logic                                  jump_valid;
  logic [rom_ctrl_pkg::DATA_WIDTH-1:0]   jump_addr;

  logic                                  instr_valid;
  logic                                  instr_ready;
  logic [rom_ctrl_pkg::DATA_WIDTH-1:0]   instr_opcode;
  logic [rom_ctrl_pkg::DATA_WIDTH-1:0]   instr_operand;
  logic [rom_ctrl_pkg::DATA_WIDTH-1:0]   instr_pc;

  logic                                  data_req;
  logic [rom_ctrl_pkg::DATA_WIDTH-1:0]   data_addr;
  logic                                  data_gnt;
  logic                                  data_valid;
  logic [rom_ctrl_pkg::DATA_WIDTH-1:0]   data_rdata;
  logic                                  data_err;

  logic [rom_ctrl_pkg::DATA_WIDTH-1:0]   rom_addr;
  logic                                  rom_enable;
  logic                                  rom_read_data_enable;
  logic [rom_ctrl_pkg::DATA_WIDTH-1:0]   rom_opcode;
  logic [rom_ctrl_pkg::DATA_WIDTH-1:0]   rom_operand;

  modport master (
    input  start, start_addr, jump_valid, jump_addr,
    output instr_valid, instr_opcode, instr_operand, instr_pc,
    input  instr_ready,
    input  data_req, data_addr,
    output data_gnt, data_valid, data_rdata, data_err,
    output rom_addr, rom_enable, rom_read_data_enable,
    input  rom_opcode, rom_operand
  );

  modport slave (
    output start, start_addr, jump_valid, jump_addr,
    input  instr_valid, instr_opcode, instr_operand, instr_pc,
    output instr_ready,
    output data_req, data_addr,
    input  data_gnt, data_valid, data_rdata, data_err,
    input  rom_addr, rom_enable, rom_read_data_enable,
    output rom_opcode, rom_operand
  );

endinterface

// File: rtl/rom_rr_arb2.sv
// Two-requester round-robin arbiter: a lone requester always wins, a tie goes to whoever lost last.
module rom_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_lastGnt1;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_lastGnt1 ? 2'b01 : 2'b10;
    end
  end

  // Reset leaves requester 0 as the most recent winner, so requester 1 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastGnt1 <= 1'b0;
    end else if (|o_gnt) begin
      r_lastGnt1 <= o_gnt[1];
    end
  end

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Program counter, one-entry decode slot and shared ROM port for instruction fetch and
// execute-stage constant reads.
module rom_fetch_ctrl
  import rom_ctrl_pkg::*;
#(
  parameter int ROM_DEPTH = ROM_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  rom_fetch_ctrl_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] ADDR_MASK = DATA_WIDTH'(ROM_DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(1);

  fetch_state_e          r_state;
  fetch_state_e          w_stateNext;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_instrValid;
  logic [DATA_WIDTH-1:0] r_instrOpcode;
  logic [DATA_WIDTH-1:0] r_instrOperand;
  logic [DATA_WIDTH-1:0] r_instrPc;
  logic                  r_dataValid;
  logic [DATA_WIDTH-1:0] r_dataRdata;
  logic                  r_dataErr;

  logic                  w_fetchWant;
  logic                  w_fetchGnt;
  logic                  w_dataGnt;
  logic                  w_startAccept;
  logic                  w_jumpAccept;
  logic                  w_haltCapture;
  logic [1:0]            w_req;
  logic [1:0]            w_gnt;

  assign w_startAccept = bus.start & (r_state != ST_RUN);
  assign w_jumpAccept  = bus.jump_valid & (r_state == ST_RUN);
  assign w_fetchWant   = (r_state == ST_RUN) & ~bus.jump_valid & (~r_instrValid | bus.instr_ready);

  // Requests are masked during reset so the ROM port and data_gnt stay quiet.
  assign w_req = {bus.data_req & ~rst, w_fetchWant & ~rst};

  rom_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign w_fetchGnt    = w_gnt[0];
  assign w_dataGnt     = w_gnt[1];
  assign w_haltCapture = w_fetchGnt & (bus.rom_opcode == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (w_startAccept) begin
          w_stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_haltCapture) begin
          w_stateNext = ST_HALTED;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Start and jump both flush the slot; a refill in the same cycle as an accept keeps it valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= '0;
      r_instrValid   <= 1'b0;
      r_instrOpcode  <= '0;
      r_instrOperand <= '0;
      r_instrPc      <= '0;
    end else if (w_startAccept) begin
      r_pc         <= bus.start_addr & ADDR_MASK;
      r_instrValid <= 1'b0;
    end else if (w_jumpAccept) begin
      r_pc         <= bus.jump_addr & ADDR_MASK;
      r_instrValid <= 1'b0;
    end else if (w_fetchGnt) begin
      r_instrOpcode  <= bus.rom_opcode;
      r_instrOperand <= bus.rom_operand;
      r_instrPc      <= r_pc;
      r_instrValid   <= 1'b1;
      r_pc           <= (r_pc + PC_STEP) & ADDR_MASK;
    end else if (r_instrValid & bus.instr_ready) begin
      r_instrValid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dataValid <= 1'b0;
      r_dataRdata <= '0;
      r_dataErr   <= 1'b0;
    end else begin
      r_dataValid <= w_dataGnt;
      if (w_dataGnt) begin
        r_dataRdata <= bus.rom_operand;
        r_dataErr   <= ~isDataReadOpcode(bus.rom_opcode);
      end
    end
  end

  always_comb begin
    bus.rom_addr = '0;
    if (w_dataGnt) begin
      bus.rom_addr = bus.data_addr & ADDR_MASK;
    end else if (w_fetchGnt) begin
      bus.rom_addr = r_pc;
    end
  end

  assign bus.rom_enable           = w_dataGnt | w_fetchGnt;
  assign bus.rom_read_data_enable = w_dataGnt;
  assign bus.data_gnt             = w_dataGnt;

  assign bus.instr_valid   = r_instrValid;
  assign bus.instr_opcode  = r_instrOpcode;
  assign bus.instr_operand = r_instrOperand;
  assign bus.instr_pc      = r_instrPc;

  assign bus.data_valid = r_dataValid;
  assign bus.data_rdata = r_dataRdata;
  assign bus.data_err   = r_dataErr;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Randomized bench for rom_fetch_ctrl: a behavioural ROM plus a transaction-level model of
// fetch, slot, arbitration and data-read rules predicts every output each cycle.
module tb_rom_fetch_ctrl;
  import rom_ctrl_pkg::*;

  localparam int DEPTH  = 16;
  localparam int CYCLES = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_fetch_ctrl_if bus ();

  rom_fetch_ctrl #(.ROM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] romMem [DEPTH];
  assign bus.rom_opcode  = romMem[bus.rom_addr[3:0]][31:16];
  assign bus.rom_operand = romMem[bus.rom_addr[3:0]][15:0];

  int compareCount  = 0;
  int mismatchCount = 0;
  int cycleNum      = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = halted.
  int          mMode;
  int          mPc;
  bit          mSlotValid;
  logic [31:0] mSlotWord;
  int          mSlotPc;
  bit          mDataValid;
  logic [15:0] mDataRdata;
  bit          mDataErr;
  bit          mLastWasData;
  bit          mFreshReset;
  bit          eFetch;
  bit          eData;
  int          eAddr;
  bit          dataPending;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, observed, expected, cycleNum);
    end
  endtask

  task automatic loadRom();
    for (int i = 0; i < DEPTH; i++) begin
      case ($urandom_range(0, 5))
        0:       romMem[i] = {16'hFFFF, 16'($urandom)};
        1, 2:    romMem[i] = {8'h31, 8'($urandom), 16'($urandom)};
        default: romMem[i] = $urandom;
      endcase
    end
  endtask

  task automatic modelReset();
    mMode        = 0;
    mPc          = 0;
    mSlotValid   = 1'b0;
    mSlotWord    = '0;
    mSlotPc      = 0;
    mDataValid   = 1'b0;
    mDataRdata   = '0;
    mDataErr     = 1'b0;
    mLastWasData = 1'b0;
    mFreshReset  = 1'b1;
  endtask

  task automatic applyStimulus(input int cyc);
    if (cyc % 150 == 0) loadRom();
    rst             = (cyc < 2) || ($urandom_range(0, 199) == 0);
    bus.start       = (mMode != 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
    bus.start_addr  = 16'($urandom);
    bus.jump_valid  = ($urandom_range(0, 11) == 0);
    bus.jump_addr   = 16'($urandom);
    bus.instr_ready = ($urandom_range(0, 3) != 0);
    if (!dataPending && $urandom_range(0, 3) == 0) begin
      dataPending   = 1'b1;
      bus.data_addr = 16'($urandom);
    end
    bus.data_req = dataPending;
  endtask

  // The port goes to whichever requester lost the previous grant when both want it.
  task automatic predictGrants();
    bit wantFetch;
    eFetch = 1'b0;
    eData  = 1'b0;
    wantFetch = (mMode == 1) && !bus.jump_valid && (!mSlotValid || bus.instr_ready);
    if (!rst) begin
      if (wantFetch && bus.data_req) begin
        eData  = !mLastWasData;
        eFetch = mLastWasData;
      end else begin
        eData  = bus.data_req;
        eFetch = wantFetch;
      end
    end
    eAddr = eData ? (int'(bus.data_addr) % DEPTH) : mPc;
  endtask

  task automatic compareAll();
    checkOutput("data_gnt", 32'(bus.data_gnt), 32'(eData));
    checkOutput("rom_enable", 32'(bus.rom_enable), 32'(eData | eFetch));
    checkOutput("rom_read_data_enable", 32'(bus.rom_read_data_enable), 32'(eData));
    if (eData || eFetch) checkOutput("rom_addr", 32'(bus.rom_addr), 32'(eAddr));
    checkOutput("instr_valid", 32'(bus.instr_valid), 32'(mSlotValid));
    if (mSlotValid || mFreshReset) begin
      checkOutput("instr_opcode", 32'(bus.instr_opcode), 32'(mSlotWord[31:16]));
      checkOutput("instr_operand", 32'(bus.instr_operand), 32'(mSlotWord[15:0]));
      checkOutput("instr_pc", 32'(bus.instr_pc), 32'(mSlotPc));
    end
    checkOutput("data_valid", 32'(bus.data_valid), 32'(mDataValid));
    if (mDataValid || mFreshReset) begin
      checkOutput("data_rdata", 32'(bus.data_rdata), 32'(mDataRdata));
      checkOutput("data_err", 32'(bus.data_err), 32'(mDataErr));
    end
  endtask

  task automatic modelStep();
    logic [31:0] word;
    if (rst) begin
      modelReset();
      return;
    end
    mFreshReset = 1'b0;
    mDataValid  = eData;
    if (eData) begin
      word       = romMem[eAddr];
      mDataRdata = word[15:0];
      mDataErr   = (word[31:24] != 8'h31);
      dataPending = 1'b0;
    end
    if (eData || eFetch) mLastWasData = eData;
    if (bus.start && mMode != 1) begin
      mPc        = int'(bus.start_addr) % DEPTH;
      mSlotValid = 1'b0;
      mMode      = 1;
    end else if (bus.jump_valid && mMode == 1) begin
      mPc        = int'(bus.jump_addr) % DEPTH;
      mSlotValid = 1'b0;
    end else if (eFetch) begin
      mSlotWord  = romMem[mPc];
      mSlotPc    = mPc;
      mSlotValid = 1'b1;
      if (mSlotWord[31:16] == 16'hFFFF) mMode = 2;
      mPc = (mPc + 1) % DEPTH;
    end else if (mSlotValid && bus.instr_ready) begin
      mSlotValid = 1'b0;
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.start_addr  = '0;
    bus.jump_valid  = 1'b0;
    bus.jump_addr   = '0;
    bus.instr_ready = 1'b0;
    bus.data_req    = 1'b0;
    bus.data_addr   = '0;
    dataPending     = 1'b0;
    loadRom();
    modelReset();
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      cycleNum = cyc;
      applyStimulus(cyc);
      #1;
      predictGrants();
      compareAll();
      modelStep();
      @(posedge clk);
      #1;
    end
    $display("[TB] run of %0d cycles complete", CYCLES);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
